dma_lite_slave: RTL and testbench

AXI4-Lite responder presenting the S2MM DMA register set (control, status, destination address low/high, length) to an AXI-Lite initiator such as the S2MM write controller. It decodes register writes and reads, launches a transfer on a committed length write, and raises `s2mm_introut` on completion. It is the counterpart that answers the initiator's `m_axi_lite_*` channels, used as the DMA-side endpoint and as the bench model for the write controller.

---
 rtl/dma_lite_slave_pkg.sv | 30 +++
 rtl/dma_lite_slave.sv | 251 +++++++++++++++++++++++++
 tb/tb_dma_lite_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_lite_slave_pkg.sv
// Shared definitions for the S2MM DMA AXI4-Lite register responder:
// register offsets, register bit positions, response codes and FSM states.
package dma_lite_slave_pkg;

    localparam logic [9:0] OFF_DMACR  = 10'h030;
    localparam logic [9:0] OFF_DMASR  = 10'h034;
    localparam logic [9:0] OFF_DA     = 10'h048;
    localparam logic [9:0] OFF_DA_MSB = 10'h04C;
    localparam logic [9:0] OFF_LENGTH = 10'h058;

    localparam int CR_RS      = 0;
    localparam int CR_IOC_EN  = 12;
    localparam int SR_HALTED  = 0;
    localparam int SR_IDLE    = 1;
    localparam int SR_IOC_IRQ = 12;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/dma_lite_slave.sv
// AXI4-Lite slave exposing the S2MM DMA register set; launches a transfer on a
// committed LENGTH write and raises a level interrupt when the datapath completes.
module dma_lite_slave
    import dma_lite_slave_pkg::*;
#(
    parameter int LEN_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       s_axi_lite_awaddr,
    input  logic             s_axi_lite_awvalid,
    output logic             s_axi_lite_awready,
    input  logic [31:0]      s_axi_lite_wdata,
    input  logic             s_axi_lite_wvalid,
    output logic             s_axi_lite_wready,
    output logic [1:0]       s_axi_lite_bresp,
    output logic             s_axi_lite_bvalid,
    input  logic             s_axi_lite_bready,
    input  logic [9:0]       s_axi_lite_araddr,
    input  logic             s_axi_lite_arvalid,
    output logic             s_axi_lite_arready,
    output logic [31:0]      s_axi_lite_rdata,
    output logic [1:0]       s_axi_lite_rresp,
    output logic             s_axi_lite_rvalid,
    input  logic             s_axi_lite_rready,
    output logic             xfer_start,
    output logic [63:0]      xfer_addr,
    output logic [LEN_W-1:0] xfer_len,
    input  logic             xfer_done,
    output logic             s2mm_introut
);

    // Readies stay low through reset and come up on the first clock after release.
    logic             r_live;
    w_state_t         r_wstate;
    w_state_t         w_wstate_nxt;
    r_state_t         r_rstate;
    r_state_t         w_rstate_nxt;

    logic             r_aw_held;
    logic             r_w_held;
    logic [9:0]       r_awaddr;
    logic [31:0]      r_wdata;
    logic [1:0]       r_bresp;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;

    logic             r_rs;
    logic             r_ioc_en;
    logic             r_idle;
    logic             r_ioc_irq;
    logic [31:0]      r_da;
    logic [31:0]      r_da_msb;
    logic [LEN_W-1:0] r_len;

    logic             r_xfer_start;
    logic [63:0]      r_xfer_addr;
    logic [LEN_W-1:0] r_xfer_len;
    logic             r_introut;

    logic             w_awready;
    logic             w_wready;
    logic             w_arready;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;
    logic             w_commit;
    logic [9:0]       w_wr_addr;
    logic [31:0]      w_wr_data;
    logic [1:0]       w_wr_resp;
    logic             w_launch;

    logic             w_rs_nxt;
    logic             w_en_nxt;
    logic             w_idle_nxt;
    logic             w_irq_nxt;
    logic [31:0]      w_da_nxt;
    logic [31:0]      w_da_msb_nxt;
    logic [LEN_W-1:0] w_len_nxt;

    logic [31:0]      w_rd_data;
    logic [1:0]       w_rd_resp;

    assign w_awready = r_live && (r_wstate == W_IDLE) && !r_aw_held;
    assign w_wready  = r_live && (r_wstate == W_IDLE) && !r_w_held;
    assign w_arready = r_live && (r_rstate == R_IDLE);
    assign w_aw_hs   = s_axi_lite_awvalid && w_awready;
    assign w_w_hs    = s_axi_lite_wvalid && w_wready;
    assign w_ar_hs   = s_axi_lite_arvalid && w_arready;

    // A write commits on the edge where the second of AW/W arrives.
    assign w_commit  = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axi_lite_awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s_axi_lite_wdata;

    always_comb begin
        w_rs_nxt     = r_rs;
        w_en_nxt     = r_ioc_en;
        w_idle_nxt   = r_idle;
        w_irq_nxt    = r_ioc_irq;
        w_da_nxt     = r_da;
        w_da_msb_nxt = r_da_msb;
        w_len_nxt    = r_len;
        w_wr_resp    = RESP_OKAY;
        w_launch     = 1'b0;
        if (w_commit) begin
            case (w_wr_addr)
                OFF_DMACR: begin
                    w_rs_nxt = w_wr_data[CR_RS];
                    w_en_nxt = w_wr_data[CR_IOC_EN];
                end
                OFF_DMASR: begin
                    if (w_wr_data[SR_IOC_IRQ]) w_irq_nxt = 1'b0;
                end
                OFF_DA:     w_da_nxt     = w_wr_data;
                OFF_DA_MSB: w_da_msb_nxt = w_wr_data;
                OFF_LENGTH: begin
                    if (!r_idle) begin
                        w_wr_resp = RESP_SLVERR;
                    end else begin
                        w_len_nxt = w_wr_data[LEN_W-1:0];
                        if (r_rs && (w_wr_data[LEN_W-1:0] != '0)) begin
                            w_idle_nxt = 1'b0;
                            w_launch   = 1'b1;
                        end
                    end
                end
                default: w_wr_resp = RESP_SLVERR;
            endcase
        end
        // Completion is applied last so it overrides a same-cycle W1C.
        if (xfer_done && !r_idle) begin
            w_idle_nxt = 1'b1;
            w_irq_nxt  = 1'b1;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (s_axi_lite_araddr)
            OFF_DMACR: begin
                w_rd_data[CR_RS]     = r_rs;
                w_rd_data[CR_IOC_EN] = r_ioc_en;
            end
            OFF_DMASR: begin
                w_rd_data[SR_HALTED]  = !r_rs;
                w_rd_data[SR_IDLE]    = r_idle;
                w_rd_data[SR_IOC_IRQ] = r_ioc_irq;
            end
            OFF_DA:     w_rd_data = r_da;
            OFF_DA_MSB: w_rd_data = r_da_msb;
            OFF_LENGTH: w_rd_data = 32'(r_len);
            default:    w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi_lite_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (s_axi_lite_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_live       <= 1'b0;
            r_wstate     <= W_IDLE;
            r_rstate     <= R_IDLE;
            r_aw_held    <= 1'b0;
            r_w_held     <= 1'b0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_bresp      <= RESP_OKAY;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_rs         <= 1'b0;
            r_ioc_en     <= 1'b0;
            r_idle       <= 1'b1;
            r_ioc_irq    <= 1'b0;
            r_da         <= '0;
            r_da_msb     <= '0;
            r_len        <= '0;
            r_xfer_start <= 1'b0;
            r_xfer_addr  <= '0;
            r_xfer_len   <= '0;
            r_introut    <= 1'b0;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_wr_resp;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s_axi_lite_awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axi_lite_wdata;
                end
            end
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
            r_rs         <= w_rs_nxt;
            r_ioc_en     <= w_en_nxt;
            r_idle       <= w_idle_nxt;
            r_ioc_irq    <= w_irq_nxt;
            r_da         <= w_da_nxt;
            r_da_msb     <= w_da_msb_nxt;
            r_len        <= w_len_nxt;
            r_xfer_start <= w_launch;
            // Transfer parameters are frozen at launch; later DA writes do not disturb them.
            if (w_launch) begin
                r_xfer_addr <= {r_da_msb, r_da};
                r_xfer_len  <= w_len_nxt;
            end
            r_introut <= w_irq_nxt && w_en_nxt;
        end
    end

    assign s_axi_lite_awready = w_awready;
    assign s_axi_lite_wready  = w_wready;
    assign s_axi_lite_bvalid  = (r_wstate == W_RESP);
    assign s_axi_lite_bresp   = r_bresp;
    assign s_axi_lite_arready = w_arready;
    assign s_axi_lite_rvalid  = (r_rstate == R_DATA);
    assign s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite_rresp   = r_rresp;
    assign xfer_start         = r_xfer_start;
    assign xfer_addr          = r_xfer_addr;
    assign xfer_len           = r_xfer_len;
    assign s2mm_introut       = r_introut;

endmodule

// File: tb/tb_dma_lite_slave.sv
// Bench for dma_lite_slave: directed register-map scenarios followed by random
// AXI-Lite traffic compared against a register-level model of the DMA.
module tb_dma_lite_slave;

    localparam int LEN_W = 26;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [9:0]       awaddr = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [31:0]      wdata = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b0;
    logic [9:0]       araddr = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b0;
    logic             xfer_start;
    logic [63:0]      xfer_addr;
    logic [LEN_W-1:0] xfer_len;
    logic             xfer_done = 1'b0;
    logic             introut;

    dma_lite_slave #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready),
        .xfer_start(xfer_start), .xfer_addr(xfer_addr), .xfer_len(xfer_len),
        .xfer_done(xfer_done), .s2mm_introut(introut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Register-level model of the DMA
    bit               m_rs, m_en, m_idle, m_irq, m_launch;
    logic [31:0]      m_da, m_dam;
    logic [LEN_W-1:0] m_len, m_xlen;
    logic [63:0]      m_xaddr;

    task automatic m_reset;
        m_rs = 0; m_en = 0; m_idle = 1; m_irq = 0; m_launch = 0;
        m_da = 0; m_dam = 0; m_len = 0; m_xlen = 0; m_xaddr = 0;
    endtask

    task automatic m_write(input logic [9:0] a, input logic [31:0] d, output logic [1:0] resp);
        m_launch = 0;
        resp = 2'b00;
        case (a)
            10'h030: begin m_rs = d[0]; m_en = d[12]; end
            10'h034: if (d[12]) m_irq = 0;
            10'h048: m_da = d;
            10'h04C: m_dam = d;
            10'h058: begin
                if (!m_idle) resp = 2'b10;
                else begin
                    m_len = d[LEN_W-1:0];
                    if (m_rs && m_len != 0) begin
                        m_idle = 0; m_launch = 1;
                        m_xaddr = {m_dam, m_da}; m_xlen = m_len;
                    end
                end
            end
            default: resp = 2'b10;
        endcase
    endtask

    task automatic m_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
        resp = 2'b00;
        case (a)
            10'h030: d = (32'(m_en) << 12) | 32'(m_rs);
            10'h034: d = (32'(m_irq) << 12) | (32'(m_idle) << 1) | 32'(!m_rs);
            10'h048: d = m_da;
            10'h04C: d = m_dam;
            10'h058: d = 32'(m_len);
            default: begin d = 0; resp = 2'b10; end
        endcase
    endtask

    task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input int daw, input int dw,
                             input int bdly, input bit done_at_commit, output logic [1:0] resp,
                             output logic s1, output logic s2, output int lat);
        bit awd = 0, wd = 0, awf, wf;
        int cyc = 0;
        awaddr = a; wdata = d;
        while (!(awd && wd) && cyc < 64) begin
            awvalid = !awd && cyc >= daw;
            wvalid  = !wd && cyc >= dw;
            awf = awvalid && awready;
            wf  = wvalid && wready;
            xfer_done = done_at_commit && (awd || awf) && (wd || wf);
            tick;
            if (awf) awd = 1;
            if (wf) wd = 1;
            cyc++;
        end
        awvalid = 0; wvalid = 0; xfer_done = 0;
        lat = cyc;
        s1 = 0; s2 = 0; resp = 2'b11;
        if (!(awd && wd)) begin
            check("aw_w_accept_timeout", 0, 1);
            return;
        end
        check("bvalid_after_commit", bvalid, 1);
        resp = bresp;
        s1 = xfer_start;
        for (int i = 0; i < bdly; i++) begin
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, resp);
            check("awready_in_resp", awready, 0);
            tick;
            if (i == 0) s2 = xfer_start;
        end
        bready = 1;
        tick;
        if (bdly == 0) s2 = xfer_start;
        bready = 0;
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic axi_read(input logic [9:0] a, input int rdly, output logic [31:0] d, output logic [1:0] r);
        int cyc = 0;
        araddr = a; arvalid = 1;
        while (!arready && cyc < 64) begin tick; cyc++; end
        if (!arready) begin
            arvalid = 0; d = 0; r = 2'b11;
            check("ar_timeout", 0, 1);
            return;
        end
        tick;
        arvalid = 0;
        check("rvalid_after_ar", rvalid, 1);
        d = rdata; r = rresp;
        for (int i = 0; i < rdly; i++) begin
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, d);
            check("arready_in_data", arready, 0);
            tick;
        end
        rready = 1;
        tick;
        rready = 0;
        check("rvalid_clear", rvalid, 0);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int daw, input int dw,
                            input int bdly, input bit done_at_commit);
        logic [1:0] eresp, resp;
        logic s1, s2;
        int lat;
        bit was_busy;
        was_busy = !m_idle;
        m_write(a, d, eresp);
        if (done_at_commit && was_busy) begin m_idle = 1; m_irq = 1; end
        axi_write(a, d, daw, dw, bdly, done_at_commit, resp, s1, s2, lat);
        check("bresp", resp, eresp);
        check("xfer_start_pulse", s1, m_launch);
        check("xfer_start_low_after", s2, 0);
        if (!m_idle) begin
            check("xfer_addr", xfer_addr, m_xaddr);
            check("xfer_len", xfer_len, 64'(m_xlen));
        end
        check("introut_after_write", introut, m_irq && m_en);
    endtask

    task automatic do_read(input logic [9:0] a, input int rdly);
        logic [31:0] d, ed;
        logic [1:0] r, er;
        m_read(a, ed, er);
        axi_read(a, rdly, d, r);
        check("rdata", d, ed);
        check("rresp", r, er);
    endtask

    task automatic do_done;
        bit busy;
        busy = !m_idle;
        xfer_done = 1;
        tick;
        xfer_done = 0;
        if (busy) begin m_idle = 1; m_irq = 1; end
        check("introut_after_done", introut, m_irq && m_en);
    endtask

    localparam logic [9:0] ADDRS [8] = '{10'h030, 10'h034, 10'h048, 10'h04C, 10'h058, 10'h03C, 10'h000, 10'h05C};

    initial begin
        logic [31:0] d, old;
        logic [1:0]  r;
        logic [1:0]  wr;
        logic        s1, s2;
        int          lat;

        m_reset;
        // Reset state
        tick; tick; tick;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_xfer_start", xfer_start, 0);
        check("rst_introut", introut, 0);
        rst = 0;
        tick;
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        check("rel_arready", arready, 1);

        axi_read(10'h034, 0, d, r);
        check("dmasr_reset", d, 32'h0000_0003);
        check("dmasr_reset_resp", r, 2'b00);

        // W leads AW by three cycles
        m_write(10'h048, 32'h1000_0000, wr);
        axi_write(10'h048, 32'h1000_0000, 3, 0, 0, 0, r, s1, s2, lat);
        check("aw_late_latency", lat, 4);
        check("aw_late_bresp", r, 2'b00);
        do_read(10'h048, 0);

        // Launch a transfer
        do_write(10'h030, 32'h0000_1001, 0, 0, 0, 0);
        do_write(10'h048, 32'h0000_2000, 1, 0, 0, 0);
        do_write(10'h04C, 32'h0000_0001, 0, 2, 0, 0);
        do_write(10'h058, 32'h0000_0400, 0, 0, 0, 0);
        check("launch_addr", xfer_addr, 64'h0000_0001_0000_2000);
        check("launch_len", xfer_len, 64'h400);
        axi_read(10'h034, 0, d, r);
        check("dmasr_busy_idle_bit", d[1], 0);

        // Busy: DA change does not move xfer_addr, LENGTH and unmapped rejected
        do_write(10'h048, 32'hDEAD_0000, 0, 0, 0, 0);
        check("busy_xfer_addr_kept", xfer_addr, 64'h0000_0001_0000_2000);
        do_write(10'h03C, 32'h1234_5678, 0, 0, 0, 0);
        do_write(10'h058, 32'h0000_0080, 0, 0, 0, 0);
        axi_read(10'h03C, 0, d, r);
        check("unmapped_rresp", r, 2'b10);
        check("unmapped_rdata", d, 0);

        // Completion and interrupt
        do_done;
        check("introut_set", introut, 1);
        axi_read(10'h034, 0, d, r);
        check("dmasr_done", d, 32'h0000_1002);
        do_write(10'h034, 32'h0000_1000, 0, 0, 0, 0);
        check("introut_cleared", introut, 0);

        // Completion coincides with W1C: set wins
        do_write(10'h058, 32'h0000_0010, 0, 0, 0, 0);
        do_write(10'h034, 32'h0000_1000, 0, 0, 0, 1);
        axi_read(10'h034, 0, d, r);
        check("w1c_vs_done", d, 32'h0000_1002);

        // Back-pressure on B and R
        do_write(10'h04C, 32'hCAFE_F00D, 0, 0, 5, 0);
        do_read(10'h04C, 5);

        // RS cleared mid-transfer
        do_write(10'h058, 32'h0000_0100, 0, 0, 0, 0);
        do_write(10'h030, 32'h0000_1000, 0, 0, 0, 0);
        do_read(10'h034, 0);
        do_done;
        do_read(10'h034, 0);

        // Read and write of the same register in one cycle
        m_read(10'h048, old, r);
        awaddr = 10'h048; wdata = 32'h5555_AAAA; awvalid = 1; wvalid = 1;
        araddr = 10'h048; arvalid = 1;
        tick;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("rw_same_bvalid", bvalid, 1);
        check("rw_same_rvalid", rvalid, 1);
        check("rw_same_old_value", rdata, old);
        bready = 1; rready = 1;
        tick;
        bready = 0; rready = 0;
        m_write(10'h048, 32'h5555_AAAA, wr);
        do_read(10'h048, 0);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            int op;
            logic [9:0] a;
            logic [31:0] dd;
            op = $urandom_range(0, 9);
            a = ADDRS[$urandom_range(0, 7)];
            dd = $urandom;
            if (a == 10'h030 && $urandom_range(0, 3) != 0) dd[0] = 1'b1;
            if (a == 10'h058) dd = ($urandom_range(0, 4) == 0) ? 32'h0 : {22'h0, dd[9:0]};
            if (op < 5) do_write(a, dd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);
            else if (op < 8) do_read(a, $urandom_range(0, 2));
            else do_done;
        end

        // Reset in the middle of pending responses
        do_write(10'h030, 32'h0000_1001, 0, 0, 0, 0);
        if (m_idle) do_write(10'h058, 32'h0000_0020, 0, 0, 0, 0);
        do_done;
        check("pre_rst_introut", introut, 1);
        awaddr = 10'h048; wdata = 32'h7777_7777; awvalid = 1; wvalid = 1;
        araddr = 10'h04C; arvalid = 1;
        tick;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("pre_rst_bvalid", bvalid, 1);
        check("pre_rst_rvalid", rvalid, 1);
        tick; tick;
        rst = 1;
        tick;
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_arready", arready, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_introut", introut, 0);
        check("mid_rst_xfer_start", xfer_start, 0);
        rst = 0;
        m_reset;
        tick;
        check("post_rst_awready", awready, 1);
        do_read(10'h034, 0);
        do_read(10'h048, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
